packet_builder: RTL and testbench

PACKET_BUILDER -- requirements
Module: packet_builder

---
 rtl/packet_builder_pkg.sv | 22 ++
 rtl/packet_builder_if.sv | 28 ++
 rtl/packet_builder_seq_table.sv | 30 +++
 rtl/packet_builder.sv | 151 +++++++++++++++
 tb/tb_packet_builder.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_builder_pkg.sv
// Shared types and constants for the packet builder slice.
package parser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA
  } state_t;

  localparam int unsigned HDR_BYTES         = 8;
  localparam int unsigned MAX_PAYLOAD_BYTES = 37;

  localparam int unsigned LEN_W    = 16;
  localparam int unsigned STREAM_W = 16;
  localparam int unsigned SEQ_W    = 32;

  localparam int unsigned PAYLOAD_W = 296;
  localparam int unsigned PLEN_W    = 6;
  localparam int unsigned WORD_W    = 32;

endpackage

// File: rtl/packet_builder_if.sv
// Payload request and packet word bus between a source/sink and the builder.
interface packet_builder_if;
  import parser_pkg::*;

  logic [0:PAYLOAD_W-1]  payloadIn;
  logic [PLEN_W-1:0]     payloadLen;
  logic [STREAM_W-1:0]   streamId;
  logic                  seqSkip;
  logic                  payloadIn_val;
  logic                  payloadIn_ready;

  logic [WORD_W-1:0]     dataOut;
  logic                  dataOut_val;
  logic                  dataOut_ready;
  logic                  dataOut_last;
  logic                  badLength;

  modport master (
    output payloadIn, payloadLen, streamId, seqSkip, payloadIn_val, dataOut_ready,
    input  payloadIn_ready, dataOut, dataOut_val, dataOut_last, badLength
  );

  modport slave (
    input  payloadIn, payloadLen, streamId, seqSkip, payloadIn_val, dataOut_ready,
    output payloadIn_ready, dataOut, dataOut_val, dataOut_last, badLength
  );

endinterface

// File: rtl/packet_builder_seq_table.sv
// Per-stream 32-bit sequence counters: one read port, one write port.
module seq_table #(
  parameter int unsigned NUM_STREAMS = 32,
  parameter int unsigned IDX_W       = 5
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data
);

  logic [31:0] seqs [NUM_STREAMS];

  // Counter storage; cleared asynchronously so every stream restarts at 0
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
        seqs[i] <= '0;
      end
    end else if (wr_en) begin
      seqs[wr_idx] <= wr_data;
    end
  end

  assign rd_data = seqs[rd_idx];

endmodule

// File: rtl/packet_builder.sv
// Packet builder: wraps a payload in a two-word header (length/stream,
// sequence) and streams it out as 32-bit words with valid/ready.
module packet_builder #(
  parameter int unsigned NUM_STREAMS       = 32,
  parameter int unsigned MAX_PAYLOAD_BYTES = 37
) (
  input  logic             clk,
  input  logic             reset_b,
  packet_builder_if.slave  bus
);
  import parser_pkg::*;

  localparam int unsigned       IDX_W   = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam logic [PLEN_W-1:0] MAX_LEN = PLEN_W'(MAX_PAYLOAD_BYTES);

  state_t               state_q, state_d;
  logic [0:PAYLOAD_W-1] pay_q;
  logic [PLEN_W-1:0]    len_q;
  logic [STREAM_W-1:0]  sid_q;
  logic                 skip_q;
  logic [3:0]           word_q;
  logic                 run_q;
  logic                 bad_q;

  logic                 in_xfer;
  logic                 len_ok;
  logic [PLEN_W-1:0]    len_m1;
  logic [3:0]           last_idx;
  logic                 last_word;
  logic [IDX_W-1:0]     idx;
  logic [SEQ_W-1:0]     cur_seq;
  logic [SEQ_W-1:0]     new_seq;
  logic                 seq_we;
  logic [LEN_W-1:0]     hdr_len;
  logic [WORD_W-1:0]    data_word;

  // run_q keeps ready low while reset is held and raises it on the first edge after
  assign bus.payloadIn_ready = run_q && (state_q == IDLE);
  assign bus.badLength       = bad_q;

  assign in_xfer   = bus.payloadIn_val && bus.payloadIn_ready;
  assign len_ok    = (bus.payloadLen != '0) && (bus.payloadLen <= MAX_LEN);
  assign len_m1    = len_q - PLEN_W'(1);
  assign last_idx  = len_m1[5:2];
  assign last_word = (word_q == last_idx);
  assign idx       = sid_q[IDX_W-1:0];
  assign new_seq   = cur_seq + (skip_q ? 32'd2 : 32'd1);
  assign hdr_len   = LEN_W'(len_q) + LEN_W'(HDR_BYTES);

  seq_table #(
    .NUM_STREAMS (NUM_STREAMS),
    .IDX_W       (IDX_W)
  ) u_seq (
    .clk     (clk),
    .reset_b (reset_b),
    .rd_idx  (idx),
    .rd_data (cur_seq),
    .wr_en   (seq_we),
    .wr_idx  (idx),
    .wr_data (new_seq)
  );

  // Select the four payload bytes of the current data word, zeroing bytes past len
  always_comb begin
    logic [7:0] pay_bytes [64];
    logic [5:0] bi;
    data_word = '0;
    bi        = '0;
    for (int unsigned k = 0; k < 64; k++) begin
      pay_bytes[k] = '0;
    end
    for (int unsigned k = 0; k < PAYLOAD_W / 8; k++) begin
      pay_bytes[k] = pay_q[8*k +: 8];
    end
    for (int unsigned j = 0; j < 4; j++) begin
      bi = {word_q, 2'(j)};
      if (bi < len_q) begin
        data_word[31-8*j -: 8] = pay_bytes[bi];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and output word; the counter is committed only with the last word
  always_comb begin
    state_d          = state_q;
    bus.dataOut_val  = 1'b0;
    bus.dataOut_last = 1'b0;
    bus.dataOut      = '0;
    seq_we           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_xfer && len_ok) state_d = HDR0;
      end
      HDR0: begin
        bus.dataOut_val = 1'b1;
        bus.dataOut     = {hdr_len, sid_q};
        if (bus.dataOut_ready) state_d = HDR1;
      end
      HDR1: begin
        bus.dataOut_val = 1'b1;
        bus.dataOut     = new_seq;
        if (bus.dataOut_ready) state_d = DATA;
      end
      DATA: begin
        bus.dataOut_val  = 1'b1;
        bus.dataOut      = data_word;
        bus.dataOut_last = last_word;
        if (bus.dataOut_ready && last_word) begin
          state_d = IDLE;
          seq_we  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, bad-length pulse and data-word index
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      pay_q  <= '0;
      len_q  <= '0;
      sid_q  <= '0;
      skip_q <= 1'b0;
      word_q <= '0;
      run_q  <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      bad_q <= in_xfer && !len_ok;
      if (in_xfer) begin
        pay_q  <= bus.payloadIn;
        len_q  <= bus.payloadLen;
        sid_q  <= bus.streamId;
        skip_q <= bus.seqSkip;
        word_q <= '0;
      end else if (state_q == DATA && bus.dataOut_ready && !last_word) begin
        word_q <= word_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_packet_builder.sv
// Self-checking bench for packet_builder: directed table, corner sequences
// and randomized packets against a byte-stream reference model.
module tb_packet_builder;
  import parser_pkg::*;

  logic clk = 1'b0;
  logic reset_b;
  always #5 clk = ~clk;

  packet_builder_if bus();

  packet_builder #(
    .NUM_STREAMS       (32),
    .MAX_PAYLOAD_BYTES (37)
  ) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] model_seq [32];
  logic [7:0]  pbytes [37];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];

  typedef struct {
    int unsigned len;
    logic [15:0] sid;
    logic        skip;
    logic [7:0]  base;
    logic        bad;
    logic [31:0] hdr0;
    logic [31:0] hdr1;
    int unsigned nwords;
    logic [31:0] lastw;
  } vec_t;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Reference: header bytes then payload, zero-padded to words, big-endian packing
  task automatic build_expected(int unsigned len, logic [15:0] sid, logic [31:0] seq);
    logic [7:0]  stream [$];
    logic [15:0] total;
    total  = 16'(len + 8);
    stream = {};
    stream.push_back(total[15:8]);
    stream.push_back(total[7:0]);
    stream.push_back(sid[15:8]);
    stream.push_back(sid[7:0]);
    stream.push_back(seq[31:24]);
    stream.push_back(seq[23:16]);
    stream.push_back(seq[15:8]);
    stream.push_back(seq[7:0]);
    for (int k = 0; k < int'(len); k++) stream.push_back(pbytes[k]);
    while (stream.size() % 4 != 0) stream.push_back(8'h00);
    exp_q = {};
    for (int w = 0; w < stream.size() / 4; w++)
      exp_q.push_back({stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]});
  endtask

  task automatic send(int unsigned len, logic [15:0] sid, logic skip);
    int unsigned guard;
    @(negedge clk);
    bus.payloadLen = 6'(len);
    bus.streamId   = sid;
    bus.seqSkip    = skip;
    for (int k = 0; k < 37; k++) bus.payloadIn[8*k +: 8] = pbytes[k];
    bus.payloadIn_val = 1'b1;
    guard = 0;
    while (bus.payloadIn_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout ready=%b required=1", bus.payloadIn_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.payloadIn_val = 1'b0;
    bus.payloadLen    = 6'($urandom);
    bus.streamId      = 16'($urandom);
    bus.seqSkip       = 1'($urandom);
    for (int k = 0; k < 37; k++) bus.payloadIn[8*k +: 8] = 8'($urandom);
  endtask

  // mode 0: always ready, 1: toggle starting at 1, 2: random
  task automatic receive(int unsigned mode, output int unsigned cycles);
    int unsigned guard, n;
    logic        r, stalled, pl;
    logic [31:0] pw;
    guard = 0; stalled = 1'b0; pl = 1'b0; pw = '0;
    got_q = {};
    while (got_q.size() < exp_q.size() && guard < 400) begin
      if (stalled) begin
        check1("hold_val", bus.dataOut_val, 1'b1);
        check("hold_word", bus.dataOut, pw);
        check1("hold_last", bus.dataOut_last, pl);
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (guard[0] == 1'b0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.dataOut_ready = r;
      stalled = 1'b0;
      if (bus.dataOut_val === 1'b1) begin
        if (r) begin
          n = got_q.size();
          check($sformatf("word%0d", n), bus.dataOut, exp_q[n]);
          check1($sformatf("last%0d", n), bus.dataOut_last, (n == exp_q.size() - 1));
          got_q.push_back(bus.dataOut);
        end else begin
          stalled = 1'b1;
          pw = bus.dataOut;
          pl = bus.dataOut_last;
        end
      end
      @(negedge clk);
      guard++;
    end
    cycles = guard;
    if (got_q.size() < exp_q.size()) begin
      checks++;
      failures++;
      $display("FAIL recv_timeout words=%0d required=%0d", got_q.size(), exp_q.size());
    end
    bus.dataOut_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic run_packet(int unsigned len, logic [15:0] sid, logic skip, int unsigned mode);
    logic [31:0] nseq;
    logic [4:0]  id;
    int unsigned cyc;
    id    = sid[4:0];
    got_q = {};
    if (len >= 1 && len <= 37) begin
      nseq = model_seq[id] + (skip ? 32'd2 : 32'd1);
      build_expected(len, sid, nseq);
      send(len, sid, skip);
      check1("hdr0_latency", bus.dataOut_val, 1'b1);
      check1("busy_ready", bus.payloadIn_ready, 1'b0);
      check1("good_no_bad", bus.badLength, 1'b0);
      receive(mode, cyc);
      if (mode == 0) check("pkt_cycles", cyc, 2 + (len + 3) / 4);
      check1("gap_val", bus.dataOut_val, 1'b0);
      check1("gap_ready", bus.payloadIn_ready, 1'b1);
      model_seq[id] = nseq;
    end else begin
      send(len, sid, skip);
      check1("bad_pulse", bus.badLength, 1'b1);
      check1("bad_no_val", bus.dataOut_val, 1'b0);
      check1("bad_ready", bus.payloadIn_ready, 1'b1);
      @(negedge clk);
      check1("bad_pulse_end", bus.badLength, 1'b0);
      check1("bad_no_val2", bus.dataOut_val, 1'b0);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    int unsigned len;

    vecs[0] = '{len:5,  sid:16'h0003, skip:1'b0, base:8'h11, bad:1'b0, hdr0:32'h000D0003, hdr1:32'd1, nwords:2,  lastw:32'h15000000};
    vecs[1] = '{len:1,  sid:16'h0010, skip:1'b0, base:8'hA0, bad:1'b0, hdr0:32'h00090010, hdr1:32'd1, nwords:1,  lastw:32'hA0000000};
    vecs[2] = '{len:4,  sid:16'h0003, skip:1'b1, base:8'h01, bad:1'b0, hdr0:32'h000C0003, hdr1:32'd3, nwords:1,  lastw:32'h01020304};
    vecs[3] = '{len:0,  sid:16'h0005, skip:1'b0, base:8'h00, bad:1'b1, hdr0:32'h0,        hdr1:32'd0, nwords:0,  lastw:32'h0};
    vecs[4] = '{len:40, sid:16'h0005, skip:1'b0, base:8'h00, bad:1'b1, hdr0:32'h0,        hdr1:32'd0, nwords:0,  lastw:32'h0};
    vecs[5] = '{len:63, sid:16'h0003, skip:1'b1, base:8'h00, bad:1'b1, hdr0:32'h0,        hdr1:32'd0, nwords:0,  lastw:32'h0};
    vecs[6] = '{len:37, sid:16'h0023, skip:1'b0, base:8'h40, bad:1'b0, hdr0:32'h002D0023, hdr1:32'd4, nwords:10, lastw:32'h64000000};
    vecs[7] = '{len:8,  sid:16'hFFE5, skip:1'b1, base:8'hF0, bad:1'b0, hdr0:32'h0010FFE5, hdr1:32'd2, nwords:2,  lastw:32'hF4F5F6F7};
    vecs[8] = '{len:6,  sid:16'h0005, skip:1'b0, base:8'h80, bad:1'b0, hdr0:32'h000E0005, hdr1:32'd3, nwords:2,  lastw:32'h84850000};

    reset_b           = 1'b0;
    bus.payloadIn     = '0;
    bus.payloadLen    = '0;
    bus.streamId      = '0;
    bus.seqSkip       = 1'b0;
    bus.payloadIn_val = 1'b0;
    bus.dataOut_ready = 1'b0;
    for (int i = 0; i < 32; i++) model_seq[i] = '0;

    #1;
    check1("rst_val", bus.dataOut_val, 1'b0);
    check1("rst_last", bus.dataOut_last, 1'b0);
    check("rst_data", bus.dataOut, 32'h0);
    check1("rst_ready", bus.payloadIn_ready, 1'b0);
    check1("rst_bad", bus.badLength, 1'b0);
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    check1("ready_before_edge", bus.payloadIn_ready, 1'b0);
    @(negedge clk);
    check1("ready_first_edge", bus.payloadIn_ready, 1'b1);

    // Directed table
    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < 37; k++)
        pbytes[k] = (k < int'(vecs[v].len)) ? 8'(vecs[v].base + 8'(k)) : 8'hEE;
      run_packet(vecs[v].len, vecs[v].sid, vecs[v].skip, 0);
      if (!vecs[v].bad) begin
        check($sformatf("tbl%0d_nwords", v), got_q.size(), vecs[v].nwords + 2);
        if (got_q.size() >= 3) begin
          check($sformatf("tbl%0d_hdr0", v), got_q[0], vecs[v].hdr0);
          check($sformatf("tbl%0d_hdr1", v), got_q[1], vecs[v].hdr1);
          check($sformatf("tbl%0d_lastw", v), got_q[got_q.size()-1], vecs[v].lastw);
        end
      end
    end
    if (got_q.size() >= 0) ;

    // Two packets on stream 7, second with loss injection
    for (int k = 0; k < 37; k++) pbytes[k] = 8'($urandom);
    run_packet(3, 16'h0007, 1'b0, 0);
    if (got_q.size() >= 2) check("s7_first_seq", got_q[1], 32'd1);
    run_packet(9, 16'h0007, 1'b1, 0);
    if (got_q.size() >= 2) check("s7_second_seq", got_q[1], 32'd3);
    check("s7_table", dut.u_seq.seqs[7], 32'd3);

    // Max length with ready toggling every cycle
    for (int k = 0; k < 37; k++) pbytes[k] = 8'(8'h30 + 8'(k));
    run_packet(37, 16'h0009, 1'b0, 1);
    check("toggle_nwords", got_q.size(), 32'd12);
    if (got_q.size() == 12) check("toggle_lastw", got_q[11], 32'h54000000);

    // Sequence wrap with stream-id aliasing onto counter 2
    @(negedge clk);
    dut.u_seq.seqs[2] = 32'hFFFF_FFFF;
    model_seq[2]      = 32'hFFFF_FFFF;
    for (int k = 0; k < 37; k++) pbytes[k] = 8'($urandom);
    run_packet(2, 16'h0022, 1'b0, 0);
    if (got_q.size() >= 2) check("wrap_seq", got_q[1], 32'h0);

    // Randomized packets with random sink back-pressure
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 9) == 0) len = $urandom_range(0, 1) ? 0 : $urandom_range(38, 63);
      else len = $urandom_range(1, 37);
      for (int k = 0; k < 37; k++) pbytes[k] = 8'($urandom);
      run_packet(len, 16'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 0 : 2);
    end

    // Reset during a stalled HDR1 of a stream-4 packet
    for (int k = 0; k < 37; k++) pbytes[k] = 8'($urandom);
    send(8, 16'h0004, 1'b0);
    check1("abort_hdr0_val", bus.dataOut_val, 1'b1);
    bus.dataOut_ready = 1'b1;
    @(negedge clk);
    bus.dataOut_ready = 1'b0;
    check("abort_hdr1", bus.dataOut, model_seq[4] + 32'd1);
    @(negedge clk);
    check("abort_hdr1_held", bus.dataOut, model_seq[4] + 32'd1);
    #2 reset_b = 1'b0;
    #1;
    check1("abort_val", bus.dataOut_val, 1'b0);
    check("abort_data", bus.dataOut, 32'h0);
    check1("abort_last", bus.dataOut_last, 1'b0);
    check1("abort_ready", bus.payloadIn_ready, 1'b0);
    for (int i = 0; i < 32; i++) model_seq[i] = '0;
    @(negedge clk);
    @(negedge clk);
    check1("abort_quiet", bus.dataOut_val, 1'b0);
    reset_b = 1'b1;
    @(negedge clk);
    check1("abort_rdy_back", bus.payloadIn_ready, 1'b1);
    check1("abort_no_words", bus.dataOut_val, 1'b0);
    for (int k = 0; k < 37; k++) pbytes[k] = 8'($urandom);
    run_packet(8, 16'h0004, 1'b0, 0);
    if (got_q.size() >= 2) check("abort_next_seq", got_q[1], 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
